// File: rtl/game_state_packer_if.sv
// Bundle between the game-state packer, the game logic feeding it and the UART transmit port.
// master: the packer view (drives tx_data/tx_start and the status pulses).
// slave: the environment view (drives the snapshot fields, trigger and tx_done).
interface game_state_packer_if;
  logic        trigger;
  logic [11:0] pl1_posx;
  logic [11:0] pl1_posy;
  logic [11:0] ball_posx;
  logic [11:0] ball_posy;
  logic [3:0]  pl1_score;
  logic [3:0]  pl2_score;
  logic        flag_point;
  logic        end_game;
  logic        tx_done;
  logic [15:0] tx_data;
  logic        tx_start;
  logic        busy;
  logic        frame_sent;
  logic        frame_err;

  modport master (
    input  trigger, pl1_posx, pl1_posy, ball_posx, ball_posy,
    input  pl1_score, pl2_score, flag_point, end_game, tx_done,
    output tx_data, tx_start, busy, frame_sent, frame_err
  );

  modport slave (
    output trigger, pl1_posx, pl1_posy, ball_posx, ball_posy,
    output pl1_score, pl2_score, flag_point, end_game, tx_done,
    input  tx_data, tx_start, busy, frame_sent, frame_err
  );
endinterface

// File: rtl/game_state_packer.sv
// Snapshots the game state on trigger and sends it as six tagged 16-bit words (last one a checksum).
// Latency: trigger -> first tx_start after 2 cycles; tx_done -> next tx_start after 1 cycle.
// Backpressure: one word in flight, next word waits for tx_done; a stalled word aborts the frame.
module game_state_packer #(
  parameter int unsigned TIMEOUT = 2_000_000
) (
  input logic                 clk,
  input logic                 rst,
  game_state_packer_if.master bus
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [2:0] LAST_IDX = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

  // Payload view of one snapshot; status is {pl1_score, pl2_score, 2'b00, flag_point, end_game}.
  typedef struct packed {
    logic [11:0] pl1_posx;
    logic [11:0] pl1_posy;
    logic [11:0] ball_posx;
    logic [11:0] ball_posy;
    logic [11:0] status;
  } snap_t;

  // Word i of a frame: tag i+1 followed by its payload; index 5 carries the XOR checksum.
  function automatic logic [15:0] word_of(input snap_t s, input logic [2:0] i);
    logic [11:0] payload;
    case (i)
      3'd0:    payload = s.pl1_posx;
      3'd1:    payload = s.pl1_posy;
      3'd2:    payload = s.ball_posx;
      3'd3:    payload = s.ball_posy;
      3'd4:    payload = s.status;
      default: payload = s.pl1_posx ^ s.pl1_posy ^ s.ball_posx ^ s.ball_posy ^ s.status;
    endcase
    return {4'(i) + 4'd1, payload};
  endfunction

  state_t          state;
  state_t          state_nxt;
  snap_t           snap_live;
  snap_t           shadow;
  logic [2:0]      idx;
  logic [WD_W-1:0] wd;
  logic            pending;
  logic [15:0]     tx_data_q;
  logic            frame_sent_q;
  logic            frame_err_q;
  logic            word_done;
  logic            last_done;
  logic            abort;

  assign snap_live.pl1_posx  = bus.pl1_posx;
  assign snap_live.pl1_posy  = bus.pl1_posy;
  assign snap_live.ball_posx = bus.ball_posx;
  assign snap_live.ball_posy = bus.ball_posy;
  assign snap_live.status    = {bus.pl1_score, bus.pl2_score, 2'b00, bus.flag_point, bus.end_game};

  // tx_done only counts while a word is actually outstanding; a done beats a same-cycle timeout.
  assign word_done = (state == WAIT) && bus.tx_done;
  assign last_done = word_done && (idx == LAST_IDX);
  assign abort     = (state == WAIT) && !bus.tx_done && (wd == WD_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a trigger arriving with the final done chains straight into the next frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.trigger) begin
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = SEND;
      SEND: state_nxt = WAIT;
      WAIT: begin
        if (word_done) begin
          if (idx != LAST_IDX) begin
            state_nxt = SEND;
          end else if (pending || bus.trigger) begin
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else if (abort) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: the SEND cycle is the launch pulse.
  always_comb begin
    bus.tx_start = (state == SEND);
    bus.busy     = (state != IDLE);
  end

  // Shadow capture in LOAD so the whole frame comes from one instant of game state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (state == LOAD) begin
      shadow <= snap_live;
    end
  end

  // Word index: reset to 0 on capture, advanced by each non-final done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 3'd0;
    end else if (state == LOAD) begin
      idx <= 3'd0;
    end else if (word_done && (idx != LAST_IDX)) begin
      idx <= idx + 3'd1;
    end
  end

  // Transmit word register, loaded on the edge entering SEND and held through WAIT.
  // Word 0 is built from the live inputs because the shadow is being written on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_q <= 16'h0000;
    end else if (state == LOAD) begin
      tx_data_q <= word_of(snap_live, 3'd0);
    end else if (word_done && (idx != LAST_IDX)) begin
      tx_data_q <= word_of(shadow, idx + 3'd1);
    end
  end

  assign bus.tx_data = tx_data_q;

  // Pending trigger: triggers while busy collapse into one flag, consumed on entry to LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (state_nxt == LOAD) begin
      pending <= 1'b0;
    end else if (abort) begin
      pending <= 1'b0;
    end else if (bus.trigger && (state != IDLE)) begin
      pending <= 1'b1;
    end
  end

  // Watchdog: counts completed WAIT cycles since the last launch, saturating at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd <= '0;
    end else if (state == SEND) begin
      wd <= '0;
    end else if ((state == WAIT) && (wd != WD_MAX)) begin
      wd <= wd + WD_W'(1);
    end
  end

  // Completion and abort pulses, registered so they appear the cycle after the deciding edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_sent_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_sent_q <= last_done;
      frame_err_q  <= abort;
    end
  end

  assign bus.frame_sent = frame_sent_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_game_state_packer.sv
// Bench for game_state_packer: UART responder plus word scoreboard, one task per scenario.
// Responder answers each tx_start with tx_done 20 cycles later unless answering is limited.
// All sampling and driving happens on the falling edge.
module tb_game_state_packer;

  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst;
  logic resp_done;
  logic spur_done;

  always #5 clk = ~clk;

  game_state_packer_if bus ();

  game_state_packer #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.tx_done = resp_done | spur_done;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int start_cnt = 0;
  int sent_cnt = 0;
  int err_cnt = 0;
  int last_start_cyc = 0;
  int answered = 0;
  int answer_limit = 1000000;
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc = cyc + 1;

  // UART model and scoreboard: every launched word is popped against the expected queue.
  initial begin : responder
    int cnt;
    logic [15:0] exp_w;
    cnt = -1;
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      resp_done = 1'b0;
      if (rst) begin
        cnt = -1;
      end else begin
        if (bus.frame_sent === 1'b1) sent_cnt++;
        if (bus.frame_err === 1'b1) err_cnt++;
        if (bus.tx_start === 1'b1) begin
          start_cnt++;
          last_start_cyc = cyc;
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL word: got %h, required no word", bus.tx_data);
          end else begin
            exp_w = exp_q.pop_front();
            if (bus.tx_data !== exp_w) $display("FAIL word: got %h, required %h", bus.tx_data, exp_w);
            else n_pass++;
          end
          if (answered < answer_limit) begin
            answered++;
            cnt = 20;
          end
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            resp_done = 1'b1;
            cnt = -1;
          end
        end
      end
    end
  end

  task automatic set_inputs(input logic [11:0] px, py, bx, by, input logic [3:0] s1, s2,
                            input logic fp, eg);
    bus.pl1_posx   = px;
    bus.pl1_posy   = py;
    bus.ball_posx  = bx;
    bus.ball_posy  = by;
    bus.pl1_score  = s1;
    bus.pl2_score  = s2;
    bus.flag_point = fp;
    bus.end_game   = eg;
  endtask

  task automatic push_frame(input logic [11:0] px, py, bx, by, input logic [3:0] s1, s2,
                            input logic fp, eg);
    logic [11:0] st;
    logic [11:0] ck;
    st = {s1, s2, 2'b00, fp, eg};
    ck = px ^ py ^ bx ^ by ^ st;
    exp_q.push_back({4'h1, px});
    exp_q.push_back({4'h2, py});
    exp_q.push_back({4'h3, bx});
    exp_q.push_back({4'h4, by});
    exp_q.push_back({4'h5, st});
    exp_q.push_back({4'h6, ck});
  endtask

  task automatic pulse_trigger();
    bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
  endtask

  task automatic wait_sent(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.frame_sent === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_starts(input int target, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (start_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.tx_data !== 16'h0000) $display("FAIL reset_tx_data: got %h, required 0000", bus.tx_data);
    else n_pass++;
    n_checks++;
    if (bus.tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b, required 0", bus.tx_start);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", bus.busy);
    else n_pass++;
    n_checks++;
    if ({bus.frame_sent, bus.frame_err} !== 2'b00)
      $display("FAIL reset_pulses: got %b, required 00", {bus.frame_sent, bus.frame_err});
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int s0, f0;
    bit ok;
    set_inputs(12'h123, 12'h2A0, 12'h200, 12'h050, 4'd3, 4'd7, 1'b1, 1'b0);
    push_frame(12'h123, 12'h2A0, 12'h200, 12'h050, 4'd3, 4'd7, 1'b1, 1'b0);
    s0 = start_cnt;
    f0 = sent_cnt;
    pulse_trigger();
    n_checks++;
    if ({bus.busy, bus.tx_start} !== 2'b10)
      $display("FAIL load_cycle: got busy/start %b, required 10", {bus.busy, bus.tx_start});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 16'h1123)
      $display("FAIL first_word_latency: got start %b data %h, required 1 1123", bus.tx_start, bus.tx_data);
    else n_pass++;
    wait_sent(400, ok);
    n_checks++;
    if (!ok) $display("FAIL basic_frame_sent: got no frame_sent, required one within 400 cycles");
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL basic_busy_after: got %b, required 0", bus.busy);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (start_cnt - s0 != 6 || sent_cnt - f0 != 1 || exp_q.size() != 0)
      $display("FAIL basic_counts: got words %0d sent %0d left %0d, required 6 1 0",
               start_cnt - s0, sent_cnt - f0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_atomic();
    bit ok;
    set_inputs(12'hABC, 12'h0FF, 12'h800, 12'h7FF, 4'd15, 4'd0, 1'b0, 1'b1);
    push_frame(12'hABC, 12'h0FF, 12'h800, 12'h7FF, 4'd15, 4'd0, 1'b0, 1'b1);
    pulse_trigger();
    @(negedge clk);
    set_inputs(12'h111, 12'h222, 12'h333, 12'h444, 4'd9, 4'd9, 1'b1, 1'b0);
    wait_sent(400, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok || exp_q.size() != 0)
      $display("FAIL atomic_frame: got sent %b left %0d, required 1 0", ok, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_pending();
    int s0, f0, busy_low;
    bit ok;
    set_inputs(12'h00F, 12'h0F0, 12'hF00, 12'h5A5, 4'd1, 4'd2, 1'b0, 1'b0);
    push_frame(12'h00F, 12'h0F0, 12'hF00, 12'h5A5, 4'd1, 4'd2, 1'b0, 1'b0);
    s0 = start_cnt;
    f0 = sent_cnt;
    busy_low = 0;
    pulse_trigger();
    wait_starts(s0 + 3, 200, ok);
    set_inputs(12'hFFF, 12'h001, 12'h3C3, 12'h0AA, 4'd4, 4'd5, 1'b1, 1'b1);
    push_frame(12'hFFF, 12'h001, 12'h3C3, 12'h0AA, 4'd4, 4'd5, 1'b1, 1'b1);
    repeat (3) begin
      pulse_trigger();
      @(negedge clk);
    end
    wait_sent(300, ok);
    n_checks++;
    if (!ok) $display("FAIL pending_first_sent: got no frame_sent, required one");
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL pending_busy_at_sent: got %b, required 1", bus.busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.tx_start !== 1'b1) $display("FAIL pending_restart: got tx_start %b, required 1", bus.tx_start);
    else n_pass++;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.frame_sent === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy !== 1'b1) busy_low++;
    end
    repeat (60) @(negedge clk);
    n_checks++;
    if (!ok || busy_low != 0 || sent_cnt - f0 != 2 || start_cnt - s0 != 12 || exp_q.size() != 0)
      $display("FAIL pending_merge: got sent %0d words %0d busy_gaps %0d left %0d, required 2 12 0 0",
               sent_cnt - f0, start_cnt - s0, busy_low, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int s0, e0, err_cyc;
    bit ok;
    set_inputs(12'h321, 12'h654, 12'h987, 12'hCBA, 4'd6, 4'd8, 1'b0, 1'b0);
    push_frame(12'h321, 12'h654, 12'h987, 12'hCBA, 4'd6, 4'd8, 1'b0, 1'b0);
    s0 = start_cnt;
    e0 = err_cnt;
    answer_limit = answered + 1;
    pulse_trigger();
    ok = 1'b0;
    err_cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.frame_err === 1'b1) begin
        ok = 1'b1;
        err_cyc = cyc;
        break;
      end
    end
    n_checks++;
    if (!ok || err_cyc - last_start_cyc != 51)
      $display("FAIL timeout_delay: got seen %b after %0d cycles, required 1 after 51", ok, err_cyc - last_start_cyc);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL timeout_busy: got %b, required 0", bus.busy);
    else n_pass++;
    repeat (60) @(negedge clk);
    n_checks++;
    if (start_cnt - s0 != 2 || err_cnt - e0 != 1)
      $display("FAIL timeout_quiet: got words %0d errs %0d, required 2 1", start_cnt - s0, err_cnt - e0);
    else n_pass++;
    exp_q.delete();
    answer_limit = 1000000;
    push_frame(12'h321, 12'h654, 12'h987, 12'hCBA, 4'd6, 4'd8, 1'b0, 1'b0);
    pulse_trigger();
    @(negedge clk);
    n_checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data[15:12] !== 4'h1)
      $display("FAIL timeout_restart_tag: got start %b tag %h, required 1 1", bus.tx_start, bus.tx_data[15:12]);
    else n_pass++;
    wait_sent(400, ok);
    n_checks++;
    if (!ok) $display("FAIL timeout_restart_frame: got no frame_sent, required one");
    else n_pass++;
  endtask

  task automatic test_spurious();
    int s0;
    bit ok;
    repeat (3) @(negedge clk);
    s0 = start_cnt;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || start_cnt != s0)
      $display("FAIL spurious_idle: got busy %b words %0d, required 0 0", bus.busy, start_cnt - s0);
    else n_pass++;
    set_inputs(12'h00A, 12'h00B, 12'h00C, 12'h00D, 4'd2, 4'd3, 1'b1, 1'b0);
    push_frame(12'h00A, 12'h00B, 12'h00C, 12'h00D, 4'd2, 4'd3, 1'b1, 1'b0);
    pulse_trigger();
    @(negedge clk);
    spur_done = bus.tx_start;
    @(negedge clk);
    spur_done = 1'b0;
    n_checks++;
    if (bus.tx_start !== 1'b0 || bus.tx_data !== 16'h100A)
      $display("FAIL spurious_send: got start %b data %h, required 0 100a", bus.tx_start, bus.tx_data);
    else n_pass++;
    wait_sent(400, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok || start_cnt - s0 != 6 || exp_q.size() != 0)
      $display("FAIL spurious_count: got sent %b words %0d, required 1 6", ok, start_cnt - s0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int s0;
    bit ok;
    set_inputs(12'h777, 12'h888, 12'h999, 12'hAAA, 4'd7, 4'd1, 1'b0, 1'b1);
    push_frame(12'h777, 12'h888, 12'h999, 12'hAAA, 4'd7, 4'd1, 1'b0, 1'b1);
    s0 = start_cnt;
    pulse_trigger();
    wait_starts(s0 + 4, 200, ok);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.tx_data, bus.tx_start, bus.busy, bus.frame_sent, bus.frame_err} !== 20'h00000)
      $display("FAIL reset_mid_outputs: got data %h start %b busy %b, required 0000 0 0",
               bus.tx_data, bus.tx_start, bus.busy);
    else n_pass++;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    s0 = start_cnt;
    repeat (60) @(negedge clk);
    n_checks++;
    if (start_cnt != s0 || bus.busy !== 1'b0)
      $display("FAIL reset_mid_quiet: got words %0d busy %b, required 0 0", start_cnt - s0, bus.busy);
    else n_pass++;
    push_frame(12'h777, 12'h888, 12'h999, 12'hAAA, 4'd7, 4'd1, 1'b0, 1'b1);
    pulse_trigger();
    wait_sent(400, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok || start_cnt - s0 != 6 || exp_q.size() != 0)
      $display("FAIL reset_mid_restart: got sent %b words %0d, required 1 6", ok, start_cnt - s0);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    spur_done = 1'b0;
    bus.trigger = 1'b0;
    set_inputs(12'h000, 12'h000, 12'h000, 12'h000, 4'd0, 4'd0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_atomic();
    test_pending();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of run, required finish within 50000 cycles");
    $fatal(1, "simulation time limit reached");
  end

endmodule
